multi_cycle_control: RTL

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/mini_mips_ctrl_pkg.sv | 55 +++++
 rtl/multi_cycle_control.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mini_mips_ctrl_pkg.sv
// Shared definitions for the mini-MIPS multi-cycle controller, its ALU
// control block and their benches: FSM states, opcodes and ALUop classes.
package mini_mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_ORI  = 4'b0011;
  localparam logic [3:0] OP_SLTI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_BEQ  = 4'b0111;
  localparam logic [3:0] OP_BNE  = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b001;
  localparam logic [2:0] ALU_FUNC = 3'b111;

  // ALU operation class used by the immediate-arithmetic instructions.
  function automatic logic [2:0] imm_alu_class(input logic [3:0] op);
    case (op)
      OP_ANDI: imm_alu_class = ALU_AND;
      OP_ORI:  imm_alu_class = ALU_OR;
      OP_SLTI: imm_alu_class = ALU_SLT;
      default: imm_alu_class = ALU_ADD;
    endcase
  endfunction

  // Opcodes 1010..1110 are unassigned.
  function automatic logic is_legal_op(input logic [3:0] op);
    is_legal_op = (op <= OP_J) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/multi_cycle_control.sv
// Moore-style multi-cycle control FSM for the mini-MIPS datapath.
// The opcode is captured in DECODE so that every later state's outputs depend
// only on registered state (plus zero / mem_ready where the datapath needs it).
module multi_cycle_control
  import mini_mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       ALUop2,
  output logic       ALUop1,
  output logic       ALUop0,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic       illegal_op
);

  state_t     state_reg, state_next;
  logic [3:0] op_reg, op_next;
  // Low from reset until the first clock edge afterwards; keeps FETCH quiet
  // so the first memory read starts on that edge, not while still in reset.
  logic       started_reg;
  logic [2:0] alu_op;

  // State, captured opcode and start flag; reset forces FETCH at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_FETCH;
      op_reg      <= OP_R;
      started_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      started_reg <= 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    case (state_reg)
      S_FETCH:    if (started_reg && mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        op_next = opcode;
        case (opcode)
          OP_R:                             state_next = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_EXEC_I;
          OP_LW, OP_SW:                     state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_next = S_BRANCH;
          OP_J:                             state_next = S_JUMP;
          OP_HALT:                          state_next = S_HALT;
          default:                          state_next = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_next = S_WB_R;
      S_WB_R:     state_next = S_FETCH;
      S_EXEC_I:   state_next = S_WB_I;
      S_WB_I:     state_next = S_FETCH;
      S_MEM_ADDR: state_next = (op_reg == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_next = S_WB_MEM;
      S_WB_MEM:   state_next = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_FETCH;
    endcase
  end

  // Output decode; every strobe and select defaults to 0 / ALU add.
  always_comb begin
    alu_op     = ALU_ADD;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (started_reg) begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        // The IR is stable during DECODE, so this pulse lasts exactly one cycle.
        illegal_op = ~is_legal_op(opcode);
      end
      S_EXEC_R: begin
        alu_op    = ALU_FUNC;
        alu_src_a = 1'b1;
      end
      S_WB_R: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_EXEC_I: begin
        alu_op    = imm_alu_class(op_reg);
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_WB_I:     reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_WB_MEM: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_BRANCH: begin
        alu_op    = ALU_SUB;
        alu_src_a = 1'b1;
        pc_source = 2'b01;
        pc_write  = (op_reg == OP_BEQ) ? zero : ~zero;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign {ALUop2, ALUop1, ALUop0} = alu_op;

endmodule
